// File: rtl/fb_arbiter_if.sv
// Bus bundle between the framebuffer arbiter, its three users and the framebuffer RAM.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface fb_arbiter_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 17
);
  logic              SCAN_REQ;
  logic [8:0]        SCAN_X;
  logic [9:0]        SCAN_Y;
  logic              SCAN_VALID;
  logic [DATA_W-1:0] SCAN_DATA;
  logic              SCAN_ERR;

  logic              WR_VALID;
  logic              WR_READY;
  logic [8:0]        WR_X;
  logic [9:0]        WR_Y;
  logic [DATA_W-1:0] WR_DATA;
  logic              WR_DROP;

  logic              CLR_START;
  logic [DATA_W-1:0] CLR_COLOR;
  logic              CLR_BUSY;

  logic [ADDR_W-1:0] FB_ADR;
  logic [DATA_W-1:0] FB_D;
  logic              FB_WE;
  logic [DATA_W-1:0] FB_Q;

  modport slave (
    input  SCAN_REQ, SCAN_X, SCAN_Y, WR_VALID, WR_X, WR_Y, WR_DATA,
           CLR_START, CLR_COLOR, FB_Q,
    output SCAN_VALID, SCAN_DATA, SCAN_ERR, WR_READY, WR_DROP, CLR_BUSY,
           FB_ADR, FB_D, FB_WE
  );

  modport master (
    output SCAN_REQ, SCAN_X, SCAN_Y, WR_VALID, WR_X, WR_Y, WR_DATA,
           CLR_START, CLR_COLOR, FB_Q,
    input  SCAN_VALID, SCAN_DATA, SCAN_ERR, WR_READY, WR_DROP, CLR_BUSY,
           FB_ADR, FB_D, FB_WE
  );
endinterface

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: scanout reads (top priority), background clear, pixel writes.
// Optional macro FB_ARB_BOUNDS_CHECK_EN drops out-of-range accesses instead of wrapping the address.
module fb_arbiter #(
  parameter int H_ACTIVE = 200,
  parameter int V_ACTIVE = 600,
  parameter int DATA_W   = 24,
  parameter int ADDR_W   = 17
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  fb_arbiter_if.slave bus
);
  localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] clr_color_q, clr_color_d;
  logic              clr_busy_q, clr_busy_d;
  logic              scan_pend_q, scan_pend_d;
  logic              s1_oob_q, s1_oob_d;
  logic              s2_vld_q, s2_vld_d;
  logic              s2_oob_q, s2_oob_d;
  logic              scan_valid_q, scan_valid_d;
  logic [DATA_W-1:0] scan_data_q, scan_data_d;
  logic              scan_err_q, scan_err_d;
  logic              wr_drop_q, wr_drop_d;
  logic [ADDR_W-1:0] fb_adr_q, fb_adr_d;
  logic [DATA_W-1:0] fb_d_q, fb_d_d;
  logic              fb_we_q, fb_we_d;

  logic              scan_slot;
  logic              wr_ready;
  logic              wr_fire;
  logic [8:0]        sel_x;
  logic [9:0]        sel_y;
  logic [ADDR_W-1:0] lin_adr;
  logic              sel_oob;

  // scan_pend_q marks the cycle in which a granted read occupies the RAM port;
  // a new request landing on it overwrites (kills) that read.
  assign scan_slot = bus.SCAN_REQ || scan_pend_q;
  assign wr_ready  = RESET_N && (state_q == IDLE) && !scan_slot;
  assign wr_fire   = bus.WR_VALID && wr_ready;

  // One shared address multiplier: scan coordinates win whenever a request is present.
  assign sel_x   = bus.SCAN_REQ ? bus.SCAN_X : bus.WR_X;
  assign sel_y   = bus.SCAN_REQ ? bus.SCAN_Y : bus.WR_Y;
  assign lin_adr = ADDR_W'(sel_y) * ADDR_W'(H_ACTIVE) + ADDR_W'(sel_x);

`ifdef FB_ARB_BOUNDS_CHECK_EN
  assign sel_oob = (sel_x >= 9'(H_ACTIVE)) || (sel_y >= 10'(V_ACTIVE));
`else
  assign sel_oob = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    clr_color_d  = clr_color_q;
    clr_busy_d   = clr_busy_q;
    fb_adr_d     = fb_adr_q;
    fb_d_d       = fb_d_q;
    fb_we_d      = 1'b0;
    wr_drop_d    = 1'b0;
    scan_pend_d  = bus.SCAN_REQ;
    scan_err_d   = scan_err_q || (bus.SCAN_REQ && scan_pend_q);
    s1_oob_d     = s1_oob_q;
    s2_vld_d     = scan_pend_q && !bus.SCAN_REQ;
    s2_oob_d     = s1_oob_q;
    scan_valid_d = s2_vld_q;
    scan_data_d  = scan_data_q;

    if (s2_vld_q) begin
      scan_data_d = s2_oob_q ? '0 : bus.FB_Q;
    end

    if (bus.SCAN_REQ) begin
      s1_oob_d = sel_oob;
      if (!sel_oob) begin
        fb_adr_d = lin_adr;
      end
    end else if (state_q == CLEAR) begin
      if (!scan_pend_q) begin
        fb_adr_d  = clr_cnt_q;
        fb_d_d    = clr_color_q;
        fb_we_d   = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADR) begin
          state_d    = IDLE;
          clr_busy_d = 1'b0;
        end
      end
    end else if (wr_fire) begin
      if (sel_oob) begin
        wr_drop_d = 1'b1;
      end else begin
        fb_adr_d = lin_adr;
        fb_d_d   = bus.WR_DATA;
        fb_we_d  = 1'b1;
      end
    end

    // A write accepted alongside CLR_START is issued above; clearing starts next cycle.
    if ((state_q == IDLE) && bus.CLR_START) begin
      state_d     = CLEAR;
      clr_color_d = bus.CLR_COLOR;
      clr_cnt_d   = '0;
      clr_busy_d  = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      clr_cnt_q    <= '0;
      clr_color_q  <= '0;
      clr_busy_q   <= 1'b0;
      scan_pend_q  <= 1'b0;
      s1_oob_q     <= 1'b0;
      s2_vld_q     <= 1'b0;
      s2_oob_q     <= 1'b0;
      scan_valid_q <= 1'b0;
      scan_data_q  <= '0;
      scan_err_q   <= 1'b0;
      wr_drop_q    <= 1'b0;
      fb_adr_q     <= '0;
      fb_d_q       <= '0;
      fb_we_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      clr_color_q  <= clr_color_d;
      clr_busy_q   <= clr_busy_d;
      scan_pend_q  <= scan_pend_d;
      s1_oob_q     <= s1_oob_d;
      s2_vld_q     <= s2_vld_d;
      s2_oob_q     <= s2_oob_d;
      scan_valid_q <= scan_valid_d;
      scan_data_q  <= scan_data_d;
      scan_err_q   <= scan_err_d;
      wr_drop_q    <= wr_drop_d;
      fb_adr_q     <= fb_adr_d;
      fb_d_q       <= fb_d_d;
      fb_we_q      <= fb_we_d;
    end
  end

  assign bus.SCAN_VALID = scan_valid_q;
  assign bus.SCAN_DATA  = scan_data_q;
  assign bus.SCAN_ERR   = scan_err_q;
  assign bus.WR_READY   = wr_ready;
  assign bus.WR_DROP    = wr_drop_q;
  assign bus.CLR_BUSY   = clr_busy_q;
  assign bus.FB_ADR     = fb_adr_q;
  assign bus.FB_D       = fb_d_q;
  assign bus.FB_WE      = fb_we_q;
endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter: a full-size instance plus a tiny 8x4 instance for a complete clear.
// Both use behavioural 1-cycle-latency RAM models preloaded with a known pattern.
module tb_fb_arbiter;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  fb_arbiter_if #(.DATA_W(24), .ADDR_W(17)) u_if ();
  fb_arbiter_if #(.DATA_W(24), .ADDR_W(5))  u_ifs ();

  fb_arbiter #(.H_ACTIVE(200), .V_ACTIVE(600), .DATA_W(24), .ADDR_W(17)) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .bus      (u_if)
  );

  fb_arbiter #(.H_ACTIVE(8), .V_ACTIVE(4), .DATA_W(24), .ADDR_W(5)) dut_s (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .bus      (u_ifs)
  );

  logic [23:0] mem   [0:131071];
  logic [23:0] mem_s [0:31];
  logic [23:0] ram_q;
  logic [23:0] ram_q_s;

  function automatic logic [23:0] pat(input int a);
    return 24'(a) ^ 24'hA50000;
  endfunction

  initial begin
    for (int i = 0; i < 131072; i++) mem[i] = pat(i);
    for (int i = 0; i < 32; i++) mem_s[i] = pat(i);
  end

  always @(posedge clk) begin
    if (u_if.FB_WE) mem[u_if.FB_ADR] <= u_if.FB_D;
    ram_q <= mem[u_if.FB_ADR];
    if (u_ifs.FB_WE) mem_s[u_ifs.FB_ADR] <= u_ifs.FB_D;
    ram_q_s <= mem_s[u_ifs.FB_ADR];
  end

  assign u_if.FB_Q  = ram_q;
  assign u_ifs.FB_Q = ram_q_s;

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    u_if.SCAN_REQ  = 1'b0; u_if.SCAN_X = '0; u_if.SCAN_Y = '0;
    u_if.WR_VALID  = 1'b0; u_if.WR_X   = '0; u_if.WR_Y   = '0; u_if.WR_DATA = '0;
    u_if.CLR_START = 1'b0; u_if.CLR_COLOR = '0;
    u_ifs.SCAN_REQ  = 1'b0; u_ifs.SCAN_X = '0; u_ifs.SCAN_Y = '0;
    u_ifs.WR_VALID  = 1'b0; u_ifs.WR_X   = '0; u_ifs.WR_Y   = '0; u_ifs.WR_DATA = '0;
    u_ifs.CLR_START = 1'b0; u_ifs.CLR_COLOR = '0;
  endtask

  initial begin
    int cyc;
    int exp_cyc;
    int exp_adr;
    int seen;
    int ready_bad;

    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b0;
    idle_inputs();

    // Reset state
    tick(); tick();
    check("rst_scan_valid", 32'(u_if.SCAN_VALID), 32'd0);
    check("rst_scan_data",  32'(u_if.SCAN_DATA),  32'd0);
    check("rst_scan_err",   32'(u_if.SCAN_ERR),   32'd0);
    check("rst_wr_ready",   32'(u_if.WR_READY),   32'd0);
    check("rst_wr_drop",    32'(u_if.WR_DROP),    32'd0);
    check("rst_clr_busy",   32'(u_if.CLR_BUSY),   32'd0);
    check("rst_fb_adr",     32'(u_if.FB_ADR),     32'd0);
    check("rst_fb_we",      32'(u_if.FB_WE),      32'd0);

    // Plain write (3,2)
    tick();
    rst_n = 1'b1;
    u_if.WR_VALID = 1'b1; u_if.WR_X = 9'd3; u_if.WR_Y = 10'd2; u_if.WR_DATA = 24'hA02040;
    #1 check("wr1_ready", 32'(u_if.WR_READY), 32'd1);
    $display("tb: write x=3 y=2 data=a02040");
    tick();
    u_if.WR_VALID = 1'b0;
    check("wr1_adr", 32'(u_if.FB_ADR), 32'd403);
    check("wr1_d",   32'(u_if.FB_D),   32'hA02040);
    check("wr1_we",  32'(u_if.FB_WE),  32'd1);
    tick();
    check("wr1_we_pulse", 32'(u_if.FB_WE),  32'd0);
    check("wr1_adr_hold", 32'(u_if.FB_ADR), 32'd403);

    // Scan (199,599) colliding with a held write to (10,1)
    u_if.SCAN_REQ = 1'b1; u_if.SCAN_X = 9'd199; u_if.SCAN_Y = 10'd599;
    u_if.WR_VALID = 1'b1; u_if.WR_X = 9'd10; u_if.WR_Y = 10'd1; u_if.WR_DATA = 24'h123456;
    #1 check("sc1_ready_c0", 32'(u_if.WR_READY), 32'd0);
    $display("tb: scan x=199 y=599 with write x=10 y=1 waiting");
    tick();
    u_if.SCAN_REQ = 1'b0;
    check("sc1_adr", 32'(u_if.FB_ADR), 32'd119999);
    check("sc1_we",  32'(u_if.FB_WE),  32'd0);
    check("sc1_valid_c1", 32'(u_if.SCAN_VALID), 32'd0);
    #1 check("sc1_ready_c1", 32'(u_if.WR_READY), 32'd0);
    tick();
    check("sc1_valid_c2", 32'(u_if.SCAN_VALID), 32'd0);
    #1 check("sc1_ready_c2", 32'(u_if.WR_READY), 32'd1);
    tick();
    u_if.WR_VALID = 1'b0;
    check("sc1_valid_c3", 32'(u_if.SCAN_VALID), 32'd1);
    check("sc1_data",     32'(u_if.SCAN_DATA),  32'(pat(119999)));
    check("sc1_wr_we",    32'(u_if.FB_WE),      32'd1);
    check("sc1_wr_adr",   32'(u_if.FB_ADR),     32'd210);
    tick();
    check("sc1_valid_c4", 32'(u_if.SCAN_VALID), 32'd0);

    // Back-to-back scans during a write: overrun, only the second returns
    u_if.WR_VALID = 1'b1; u_if.WR_X = 9'd1; u_if.WR_Y = 10'd1; u_if.WR_DATA = 24'h0F0F0F;
    #1 check("ov_wr_ready", 32'(u_if.WR_READY), 32'd1);
    tick();
    u_if.WR_VALID = 1'b0;
    check("ov_wr_inflight", 32'(u_if.FB_WE), 32'd1);
    u_if.SCAN_REQ = 1'b1; u_if.SCAN_X = 9'd5; u_if.SCAN_Y = 10'd5;
    $display("tb: scan x=5 y=5 then x=7 y=9 back to back");
    tick();
    check("ov_err_before", 32'(u_if.SCAN_ERR), 32'd0);
    u_if.SCAN_X = 9'd7; u_if.SCAN_Y = 10'd9;
    tick();
    u_if.SCAN_REQ = 1'b0;
    check("ov_err_set", 32'(u_if.SCAN_ERR), 32'd1);
    tick();
    check("ov_first_lost", 32'(u_if.SCAN_VALID), 32'd0);
    tick();
    check("ov_second_valid", 32'(u_if.SCAN_VALID), 32'd1);
    check("ov_second_data",  32'(u_if.SCAN_DATA),  32'(pat(1807)));
    tick();
    check("ov_valid_pulse", 32'(u_if.SCAN_VALID), 32'd0);
    check("ov_err_sticky",  32'(u_if.SCAN_ERR),   32'd1);

    // Out-of-range coordinates
    u_if.WR_VALID = 1'b1; u_if.WR_X = 9'd200; u_if.WR_Y = 10'd0; u_if.WR_DATA = 24'h111111;
    #1 check("oob_wr_ready", 32'(u_if.WR_READY), 32'd1);
    $display("tb: write x=200 y=0");
    tick();
`ifdef FB_ARB_BOUNDS_CHECK_EN
    u_if.WR_VALID = 1'b0;
    check("oob_wr_we",   32'(u_if.FB_WE),   32'd0);
    check("oob_wr_drop", 32'(u_if.WR_DROP), 32'd1);
    check("oob_wr_adr",  32'(u_if.FB_ADR),  32'd1807);
    tick();
    check("oob_drop_pulse", 32'(u_if.WR_DROP), 32'd0);
    u_if.SCAN_REQ = 1'b1; u_if.SCAN_X = 9'd0; u_if.SCAN_Y = 10'd600;
    $display("tb: scan x=0 y=600");
    tick();
    u_if.SCAN_REQ = 1'b0;
    check("oob_sc_adr", 32'(u_if.FB_ADR), 32'd1807);
    tick(); tick();
    check("oob_sc_valid", 32'(u_if.SCAN_VALID), 32'd1);
    check("oob_sc_data",  32'(u_if.SCAN_DATA),  32'd0);
`else
    check("wrap_wr_we",   32'(u_if.FB_WE),   32'd1);
    check("wrap_wr_adr",  32'(u_if.FB_ADR),  32'd200);
    check("wrap_wr_drop", 32'(u_if.WR_DROP), 32'd0);
    u_if.WR_X = 9'd511; u_if.WR_Y = 10'd1023; u_if.WR_DATA = 24'h222222;
    $display("tb: write x=511 y=1023");
    tick();
    u_if.WR_VALID = 1'b0;
    check("wrap_wr2_adr", 32'(u_if.FB_ADR), 32'd74039);
    u_if.SCAN_REQ = 1'b1; u_if.SCAN_X = 9'd0; u_if.SCAN_Y = 10'd600;
    $display("tb: scan x=0 y=600");
    tick();
    u_if.SCAN_REQ = 1'b0;
    check("wrap_sc_adr", 32'(u_if.FB_ADR), 32'd120000);
    tick(); tick();
    check("wrap_sc_valid", 32'(u_if.SCAN_VALID), 32'd1);
    check("wrap_sc_data",  32'(u_if.SCAN_DATA),  32'(pat(120000)));
`endif
    tick();

    // Clear with a concurrent write, scans every 5 cycles, reset at counter 5000
    u_if.CLR_START = 1'b1; u_if.CLR_COLOR = 24'h000000;
    u_if.WR_VALID = 1'b1; u_if.WR_X = 9'd4; u_if.WR_Y = 10'd0; u_if.WR_DATA = 24'h777777;
    #1 check("clr_wr_ready", 32'(u_if.WR_READY), 32'd1);
    $display("tb: clear start color=000000 with write x=4 y=0");
    tick();
    u_if.CLR_START = 1'b0;
    u_if.WR_X = 9'd6;
    check("clr_wr_first_adr", 32'(u_if.FB_ADR),   32'd4);
    check("clr_wr_first_d",   32'(u_if.FB_D),     32'h777777);
    check("clr_busy_rise",    32'(u_if.CLR_BUSY), 32'd1);
    seen = 0; cyc = 0; exp_cyc = -100; exp_adr = 0; ready_bad = 0;
    while (seen < 5000 && cyc < 12000) begin
      tick();
      if (u_if.FB_WE) begin
        check("clr_adr", 32'(u_if.FB_ADR), 32'(seen));
        check("clr_dat", 32'(u_if.FB_D),   32'd0);
        seen++;
      end
      check("clr_scan_valid", 32'(u_if.SCAN_VALID), 32'(cyc == exp_cyc));
      if (cyc == exp_cyc) check("clr_scan_data", 32'(u_if.SCAN_DATA), 32'(pat(exp_adr)));
      if (cyc % 5 == 0) begin
        u_if.SCAN_REQ = 1'b1;
        u_if.SCAN_X   = 9'((cyc / 5) % 200);
        u_if.SCAN_Y   = 10'(500 + (cyc / 5) % 100);
        exp_adr       = (500 + (cyc / 5) % 100) * 200 + (cyc / 5) % 200;
        exp_cyc       = cyc + 3;
      end else begin
        u_if.SCAN_REQ = 1'b0;
      end
      #1 if (u_if.WR_READY) ready_bad++;
      cyc++;
    end
    check("clr_count",     32'(seen),          32'd5000);
    check("clr_ready_low", 32'(ready_bad),     32'd0);
    check("clr_busy_mid",  32'(u_if.CLR_BUSY), 32'd1);
    $display("tb: reset asserted at clear counter 5000");
    rst_n = 1'b0;
    #1;
    check("arst_busy",   32'(u_if.CLR_BUSY),   32'd0);
    check("arst_err",    32'(u_if.SCAN_ERR),   32'd0);
    check("arst_adr",    32'(u_if.FB_ADR),     32'd0);
    check("arst_d",      32'(u_if.FB_D),       32'd0);
    check("arst_data",   32'(u_if.SCAN_DATA),  32'd0);
    check("arst_ready",  32'(u_if.WR_READY),   32'd0);
    u_if.SCAN_REQ = 1'b0; u_if.WR_VALID = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #1 check("post_rst_ready", 32'(u_if.WR_READY), 32'd1);
    u_if.WR_VALID = 1'b1; u_if.WR_X = 9'd9; u_if.WR_Y = 10'd0; u_if.WR_DATA = 24'hABCDEF;
    $display("tb: write x=9 y=0 after reset");
    tick();
    u_if.WR_VALID = 1'b0;
    check("post_rst_we",   32'(u_if.FB_WE),    32'd1);
    check("post_rst_adr",  32'(u_if.FB_ADR),   32'd9);
    check("post_rst_busy", 32'(u_if.CLR_BUSY), 32'd0);

    // Complete clear on the 8x4 instance, with an ignored second CLR_START
    u_ifs.CLR_START = 1'b1; u_ifs.CLR_COLOR = 24'h3C3C3C;
    $display("tb: small clear start color=3c3c3c");
    tick();
    u_ifs.CLR_START = 1'b0;
    u_ifs.WR_VALID = 1'b1; u_ifs.WR_X = 9'd2; u_ifs.WR_Y = 10'd2; u_ifs.WR_DATA = 24'h555555;
    check("s_busy_rise", 32'(u_ifs.CLR_BUSY), 32'd1);
    seen = 0; cyc = 0; exp_cyc = -100; ready_bad = 0;
    while (seen < 32 && cyc < 400) begin
      tick();
      if (u_ifs.FB_WE) begin
        check("s_clr_adr",  32'(u_ifs.FB_ADR),   32'(seen));
        check("s_clr_dat",  32'(u_ifs.FB_D),     32'h3C3C3C);
        check("s_clr_busy", 32'(u_ifs.CLR_BUSY), 32'(seen != 31));
        seen++;
      end
      check("s_scan_valid", 32'(u_ifs.SCAN_VALID), 32'(cyc == exp_cyc));
      u_ifs.SCAN_REQ = (cyc % 5 == 0);
      u_ifs.SCAN_X = 9'd1; u_ifs.SCAN_Y = 10'd1;
      if (cyc % 5 == 0) exp_cyc = cyc + 3;
      u_ifs.CLR_START = (cyc == 7);
      if (cyc == 7) u_ifs.CLR_COLOR = 24'h999999;
      #1 if (seen < 32 && u_ifs.WR_READY) ready_bad++;
      cyc++;
    end
    check("s_clr_count",     32'(seen),      32'd32);
    check("s_clr_ready_low", 32'(ready_bad), 32'd0);
    u_ifs.SCAN_REQ = 1'b0; u_ifs.WR_VALID = 1'b0; u_ifs.CLR_START = 1'b0;
    tick();
    #1 check("s_idle_ready", 32'(u_ifs.WR_READY), 32'd1);
    check("s_idle_busy", 32'(u_ifs.CLR_BUSY), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM between three users: the VGA scanout reader, a pixel writer, and a built-in background clear engine.
- Converts (x,y) pixel coordinates into linear RAM addresses.
- Gives scanout absolute priority. Scanout issues at most one request per 5 clocks (10 MHz pixel rate on CLOCK_50), so write and clear traffic fills the idle slots.

Parameters:
- H_ACTIVE, 200, visible pixels per line.
- V_ACTIVE, 600, visible lines.
- DATA_W, 24, pixel width (RGB 8:8:8).
- ADDR_W, 17, RAM address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.

Ports:
- CLOCK_50  in  1  sole clock; all logic on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- SCAN_REQ  in  1  one-cycle read request pulse.
- SCAN_X  in  9  read x coordinate.
- SCAN_Y  in  10  read y coordinate.
- SCAN_VALID  out  1  read data valid pulse.
- SCAN_DATA  out  DATA_W  read pixel.
- SCAN_ERR  out  1  sticky overrun flag.
- WR_VALID  in  1  write request.
- WR_READY  out  1  write accepted when WR_VALID and WR_READY are both high.
- WR_X  in  9  write x coordinate.
- WR_Y  in  10  write y coordinate.
- WR_DATA  in  DATA_W  write pixel.
- WR_DROP  out  1  pulse: accepted write discarded.
- CLR_START  in  1  pulse: start clear.
- CLR_COLOR  in  DATA_W  fill value, sampled on CLR_START.
- CLR_BUSY  out  1  clear in progress.
- FB_ADR  out  ADDR_W  RAM address, registered.
- FB_D  out  DATA_W  RAM write data, registered.
- FB_WE  out  1  RAM write enable, registered.
- FB_Q  in  DATA_W  RAM read data, 1-cycle registered latency.

Behaviour:
- Reset values: all outputs 0, including SCAN_ERR and CLR_BUSY. The pending-scan register is emptied, the FSM goes to IDLE, and the clear counter is 0. Reset mid-clear abandons the clear; RAM contents are left partially cleared.
- Address computation: ADDR = y*H_ACTIVE + x, computed at ADDR_W width with no truncation. Maximum value is 119999.
- Pending-scan register:
  - SCAN_REQ loads a 1-entry pending register.
  - If the register is still full when a new SCAN_REQ arrives, the new request overwrites the old one, the old request is lost, and SCAN_ERR is set. SCAN_ERR clears only on reset.
- Slot arbitration, one RAM access per cycle, in this order:
  1. A SCAN_REQ in the current cycle, or a pending scan request.
  2. In CLEAR state: the clear engine.
  3. In IDLE state: the writer.
- WR_READY is combinational: high only when the FSM is in IDLE and there is no SCAN_REQ and no pending scan. Deasserted for the whole duration of CLEAR.
- Scan read timing:
  - Request granted in cycle 0: FB_ADR valid and FB_WE=0 in cycle 1; FB_Q valid in cycle 2.
  - SCAN_DATA registered at the end of cycle 2; SCAN_VALID high for exactly cycle 3.
  - Latency is fixed at 3 cycles from grant. Grant is always the request cycle unless the request is waiting in the pending register.
- Write timing: an accepted write drives FB_ADR, FB_D and FB_WE=1 in the next cycle. FB_WE is a single-cycle pulse.
- FSM:
  - IDLE -> CLEAR on CLR_START. On entry: latch CLR_COLOR, set the clear counter to 0, set CLR_BUSY=1.
  - CLEAR: each non-scan cycle writes CLR_COLOR at the counter address and increments the counter.
  - CLEAR -> IDLE after the write to address H_ACTIVE*V_ACTIVE-1 is issued. CLR_BUSY falls in the same cycle FB_WE for that last write is asserted.
  - CLR_START while already in CLEAR is ignored.
  - A write accepted in the same cycle as CLR_START completes first. The clear then begins in the following cycle.
- Bounds (see optional feature):
  - Scan read with x >= H_ACTIVE or y >= V_ACTIVE: no RAM access, SCAN_DATA = 0, latency still 3.
  - Write with x >= H_ACTIVE or y >= V_ACTIVE: accepted (READY honoured), not performed, WR_DROP pulses one cycle after acceptance.
- Between accesses FB_ADR and FB_D hold their last values; FB_WE=0.

Optional Feature:
- FB_ARB_BOUNDS_CHECK_EN defined: out-of-range handling exactly as described under Bounds.
- Not defined:
  - No comparators are built.
  - Coordinates map straight through the address formula; an out-of-range address wraps modulo 2^ADDR_W.
  - WR_DROP is tied to 0.
  - Out-of-range scan reads access the RAM.

Test Plan:
- Write (x=3,y=2,data=0xA02040) with no scan traffic -> WR_READY=1; next cycle FB_ADR=403, FB_D=0xA02040, FB_WE=1 for one cycle.
- SCAN_REQ (x=199,y=599) with WR_VALID held high in the same cycle -> WR_READY=0; FB_ADR=119999 with FB_WE=0 the next cycle; SCAN_VALID 3 cycles after the request with SCAN_DATA equal to RAM content; the write proceeds in the following free cycle.
- Two SCAN_REQ pulses in consecutive cycles while a write is in flight -> SCAN_ERR=1 and stays set; only the second request returns data.
- CLR_START with CLR_COLOR=0x000000, with SCAN_REQ every 5 cycles -> 120000 writes in address order 0..119999; every scan returns with latency 3; CLR_BUSY falls on the final write; WR_READY stays 0 throughout.
- Assert RESET_N=0 at clear counter = 5000 -> all outputs go to 0 immediately without a clock edge; after release, FSM in IDLE, WR_READY=1.
- With FB_ARB_BOUNDS_CHECK_EN: write at x=200,y=0 -> no FB_WE, WR_DROP pulses; scan at y=600 -> SCAN_DATA=0 at latency 3, no RAM access.
